// File: rtl/gshare_bht_banked.sv
// Banked gshare BHT: INSTR_PER_FETCH predictions per fetch block, combinational (0-cycle) read, writes visible next cycle.
// No backpressure: updates during the flush sweep are dropped; init_busy_o reports the sweep.
module gshare_bht_banked #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned HIST_BITS       = 8,
    parameter int unsigned VLEN            = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [HIST_BITS-1:0]       ghr_o,
    input  logic                       spec_valid_i,
    input  logic                       spec_taken_i,
    input  logic                       restore_i,
    input  logic [HIST_BITS-1:0]       restore_ghr_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    input  logic [HIST_BITS-1:0]       upd_ghr_i,
    input  logic                       upd_taken_i,
    output logic                       init_busy_o
);
    localparam int unsigned IPF      = INSTR_PER_FETCH;
    localparam int unsigned NR_ROWS  = NR_ENTRIES / IPF;
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned OFF      = $clog2(IPF) + 1;
    localparam int unsigned BANK_W   = (IPF > 1) ? $clog2(IPF) : 1;

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ROW_BITS-1:0] sweep_q, sweep_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    // Table storage carries no reset; the INIT sweep establishes its contents.
    logic                valid_q [NR_ROWS][IPF];
    logic [CTR_BITS-1:0] ctr_q   [NR_ROWS][IPF];

    logic [ROW_BITS-1:0] rd_row, up_row;
    logic [BANK_W-1:0]   up_bank;
    logic [CTR_BITS-1:0] up_cur, up_ctr;
    logic                init_wr, upd_wr;

    assign rd_row = vpc_i[OFF+ROW_BITS-1:OFF] ^ ROW_BITS'(ghr_q);
    assign up_row = upd_pc_i[OFF+ROW_BITS-1:OFF] ^ ROW_BITS'(upd_ghr_i);

    generate
        if (IPF > 1) begin : g_bank
            assign up_bank = upd_pc_i[OFF-1:1];
        end else begin : g_single
            assign up_bank = '0;
        end
    endgenerate

    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i[VLEN-1:OFF+ROW_BITS], vpc_i[OFF-1:0],
                              upd_pc_i[VLEN-1:OFF+ROW_BITS], upd_pc_i[0]};

    assign init_wr = !flush_i && (state_q == ST_INIT);
    assign upd_wr  = !flush_i && (state_q == ST_RUN) && upd_valid_i && !debug_mode_i;

    assign up_cur = ctr_q[up_row][up_bank];

    always_comb begin
        up_ctr = up_cur;
        if (upd_taken_i) begin
            if (up_cur != CTR_MAX) up_ctr = up_cur + CTR_BITS'(1);
        end else begin
            if (up_cur != '0) up_ctr = up_cur - CTR_BITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ghr_d   = ghr_q;
        if (flush_i) begin
            state_d = ST_INIT;
            sweep_d = '0;
            ghr_d   = '0;
        end else begin
            if (state_q == ST_INIT) begin
                sweep_d = sweep_q + ROW_BITS'(1);
                if (sweep_q == LAST_ROW) state_d = ST_RUN;
            end
            // Restore carries the corrected outcome already, so it beats a same-cycle shift.
            if (restore_i) begin
                ghr_d = restore_ghr_i;
            end else if (spec_valid_i && !debug_mode_i) begin
                ghr_d = (ghr_q << 1) | HIST_BITS'(spec_taken_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (init_wr) begin
            for (int b = 0; b < IPF; b++) begin
                valid_q[sweep_q][b] <= 1'b0;
                ctr_q[sweep_q][b]   <= CTR_INIT;
            end
        end else if (upd_wr) begin
            valid_q[up_row][up_bank] <= 1'b1;
            ctr_q[up_row][up_bank]   <= up_ctr;
        end
    end

    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        for (int i = 0; i < IPF; i++) begin
            pred_valid_o[i] = (state_q == ST_RUN) && valid_q[rd_row][i];
            pred_taken_o[i] = (state_q == ST_RUN) && ctr_q[rd_row][i][CTR_BITS-1];
        end
    end

    assign ghr_o       = ghr_q;
    assign init_busy_o = (state_q == ST_INIT);

endmodule

// File: tb/tb_gshare_bht_banked.sv
// Bench for gshare_bht_banked at default geometry (1024 entries, 2 banks, 2-bit counters, 8-bit GHR).
module tb_gshare_bht_banked;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        debug_mode_i;
    logic [38:0] vpc_i;
    logic [1:0]  pred_valid_o;
    logic [1:0]  pred_taken_o;
    logic [7:0]  ghr_o;
    logic        spec_valid_i;
    logic        spec_taken_i;
    logic        restore_i;
    logic [7:0]  restore_ghr_i;
    logic        upd_valid_i;
    logic [38:0] upd_pc_i;
    logic [7:0]  upd_ghr_i;
    logic        upd_taken_i;
    logic        init_busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [1:0] vld;
        logic [1:0] tkn;
        logic [7:0] ghr;
    } exp_t;

    exp_t sb_q[$];

    gshare_bht_banked dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .debug_mode_i  (debug_mode_i),
        .vpc_i         (vpc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o),
        .ghr_o         (ghr_o),
        .spec_valid_i  (spec_valid_i),
        .spec_taken_i  (spec_taken_i),
        .restore_i     (restore_i),
        .restore_ghr_i (restore_ghr_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_ghr_i     (upd_ghr_i),
        .upd_taken_i   (upd_taken_i),
        .init_busy_o   (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] v, input logic [1:0] t, input logic [7:0] g);
        exp_t e;
        e.tag = tag;
        e.vld = v;
        e.tkn = t;
        e.ghr = g;
        sb_q.push_back(e);
    endtask

    // Sample 1 time unit after the caller's position, which is never on a rising edge.
    task automatic pop_cmp();
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_vld"}, {30'd0, pred_valid_o}, {30'd0, e.vld});
            chk({e.tag, "_tkn"}, {30'd0, pred_taken_o}, {30'd0, e.tkn});
            chk({e.tag, "_ghr"}, {24'd0, ghr_o}, {24'd0, e.ghr});
        end
    endtask

    task automatic upd(input logic [38:0] pc, input logic [7:0] g, input logic t);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_ghr_i   = g;
        upd_taken_i = t;
        @(posedge clk_i);
        #1;
        upd_valid_i = 1'b0;
    endtask

    task automatic spec(input logic t);
        spec_valid_i = 1'b1;
        spec_taken_i = t;
        @(posedge clk_i);
        #1;
        spec_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [1:0] any_vld;

        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        debug_mode_i  = 1'b0;
        vpc_i         = 39'h100;
        spec_valid_i  = 1'b0;
        spec_taken_i  = 1'b0;
        restore_i     = 1'b0;
        restore_ghr_i = 8'h00;
        upd_valid_i   = 1'b0;
        upd_pc_i      = '0;
        upd_ghr_i     = '0;
        upd_taken_i   = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("reset_busy", {31'd0, init_busy_o}, 32'd1);
        chk("reset_ghr", {24'd0, ghr_o}, 32'd0);
        chk("reset_vld", {30'd0, pred_valid_o}, 32'd0);
        chk("reset_tkn", {30'd0, pred_taken_o}, 32'd0);

        // Count busy cycles after reset release.
        rst_ni  = 1'b1;
        n       = 0;
        any_vld = '0;
        while (init_busy_o && n < 2000) begin
            any_vld |= pred_valid_o;
            n++;
            @(negedge clk_i);
        end
        chk("init_cycles", n, 32'd512);
        chk("init_pred_vld", {30'd0, any_vld}, 32'd0);

        push("post_init", 2'b00, 2'b11, 8'h00);
        pop_cmp();

        // Counter walk on pc 0x100 (row 0x40, bank 0).
        repeat (3) upd(39'h100, 8'h00, 1'b0);
        push("nt3", 2'b01, 2'b10, 8'h00);
        pop_cmp();
        repeat (4) upd(39'h100, 8'h00, 1'b1);
        push("t4", 2'b01, 2'b11, 8'h00);
        pop_cmp();
        upd(39'h100, 8'h00, 1'b0);
        push("sat_dec1", 2'b01, 2'b11, 8'h00);
        pop_cmp();
        upd(39'h100, 8'h00, 1'b0);
        push("sat_dec2", 2'b01, 2'b10, 8'h00);
        pop_cmp();

        // Update and predict the same row in one cycle.
        @(negedge clk_i);
        vpc_i       = 39'h200;
        upd_valid_i = 1'b1;
        upd_pc_i    = 39'h200;
        upd_ghr_i   = 8'h00;
        upd_taken_i = 1'b1;
        push("same_old", 2'b00, 2'b11, 8'h00);
        pop_cmp();
        @(posedge clk_i);
        #1;
        upd_valid_i = 1'b0;
        push("same_new", 2'b01, 2'b11, 8'h00);
        pop_cmp();
        upd(39'h202, 8'h00, 1'b1);
        push("bank1", 2'b11, 2'b11, 8'h00);
        pop_cmp();

        // GHR shift, restore priority, and GHR-hashed indexing.
        repeat (3) spec(1'b1);
        chk("ghr_spec3", {24'd0, ghr_o}, 32'h07);
        restore_i     = 1'b1;
        restore_ghr_i = 8'h05;
        spec_valid_i  = 1'b1;
        spec_taken_i  = 1'b1;
        @(posedge clk_i);
        #1;
        restore_i    = 1'b0;
        spec_valid_i = 1'b0;
        chk("ghr_restore", {24'd0, ghr_o}, 32'h05);
        vpc_i = 39'h100;
        push("ghr_row_miss", 2'b00, 2'b11, 8'h05);
        pop_cmp();
        upd(39'h100, 8'h05, 1'b0);
        push("ghr_row_hit", 2'b01, 2'b10, 8'h05);
        pop_cmp();

        // Debug mode freezes table and GHR.
        debug_mode_i = 1'b1;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 39'h300;
        upd_ghr_i    = 8'h05;
        upd_taken_i  = 1'b1;
        spec_valid_i = 1'b1;
        spec_taken_i = 1'b1;
        @(posedge clk_i);
        #1;
        upd_valid_i  = 1'b0;
        spec_valid_i = 1'b0;
        vpc_i        = 39'h300;
        push("dbg", 2'b00, 2'b11, 8'h05);
        pop_cmp();
        debug_mode_i = 1'b0;

        // Flush beats a same-cycle spec shift, then restart the sweep at row 200.
        flush_i      = 1'b1;
        spec_valid_i = 1'b1;
        spec_taken_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i      = 1'b0;
        spec_valid_i = 1'b0;
        chk("flush_ghr", {24'd0, ghr_o}, 32'd0);
        chk("flush_busy", {31'd0, init_busy_o}, 32'd1);

        upd_valid_i = 1'b1;
        upd_pc_i    = 39'h100;
        upd_ghr_i   = 8'h00;
        upd_taken_i = 1'b1;
        repeat (200) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i      = 1'b0;
        spec_valid_i = 1'b1;
        spec_taken_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (init_busy_o && n < 2000) begin
            n++;
            @(negedge clk_i);
            if (n == 1) spec_valid_i = 1'b0;
        end
        upd_valid_i = 1'b0;
        chk("flush_cycles", n, 32'd512);
        chk("sweep_ghr", {24'd0, ghr_o}, 32'h01);

        // Row 0x40 reached via ghr 1: vpc row bits 0x41.
        vpc_i = 39'h104;
        push("flush_clear", 2'b00, 2'b11, 8'h01);
        pop_cmp();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
